// File: rtl/stage_mem_pkg.sv
// Shared definitions for the memory-access stage: opcodes, funct3 width codes,
// FSM encoding and trap cause codes consumed later by write-back.
package stage_mem_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPI    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] CAUSE_INST_MIS = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_LD_MIS   = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
  localparam logic [3:0] CAUSE_ST_MIS   = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane logic: request side builds sel/lane data/misaligned flag, response
// side extracts and extends the addressed load field.
module mem_align
  import stage_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] st_data,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [2:0]  rsp_funct3,
  input  logic [31:0] rsp_data,
  output logic [3:0]  sel,
  output logic [31:0] lane_data,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    sel        = 4'b1111;
    lane_data  = st_data;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        sel       = 4'b0001 << addr_lo;
        lane_data = {4{st_data[7:0]}};
      end
      2'b01: begin
        sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{st_data[15:0]}};
        misaligned = addr_lo[0];
      end
      default: misaligned = |addr_lo;
    endcase
  end

  assign shifted = rsp_data >> {rsp_addr_lo, 3'b000};

  always_comb begin
    case (rsp_funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Memory-access stage: registers the EX bundle and runs one Wishbone-classic
// data cycle for loads/stores, presenting a single-cycle valid bundle to WB.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rs1_i,
  input  logic [31:0] alu_d_i,
  input  logic [31:0] st_d_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_data_i,
  input  logic        e_illegal_inst_i,
  input  logic        e_inst_addr_mis_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic [2:0]  funct3_o,
  output logic [4:0]  rs1_o,
  output logic [31:0] alu_d_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_data_o,
  output logic [31:0] mem_d_o,
  output logic [31:0] mem_addr_o,
  output logic        e_illegal_inst_o,
  output logic        e_inst_addr_mis_o,
  output logic        e_ld_addr_mis_o,
  output logic        e_st_addr_mis_o,
  output logic        e_ld_fault_o,
  output logic        e_st_fault_o,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_we_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i,
  output logic [1:0]  state_o
);

  localparam logic [7:0] TO_LAST = (TIMEOUT_CYC == 0) ? 8'd0 : 8'(TIMEOUT_CYC - 1);

  state_t      state, state_nx;
  logic [7:0]  to_cnt;
  logic        is_ld, is_st, is_mem, up_err, f3_bad, mis, go_bus, ok_mem;
  logic        to_hit, bus_end, bus_fault, accept, deliver;
  logic [3:0]  al_sel;
  logic [31:0] al_dat, ld_ext;

  logic        valid_q, cyc_q, we_q;
  logic [31:0] pc_q, instr_q, alu_q, csr_data_q, mem_d_q, addr_q, dat_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rs1_q;
  logic [11:0] csr_addr_q;
  logic [3:0]  sel_q;
  logic        e_ill_q, e_imis_q, e_lmis_q, e_smis_q, e_lflt_q, e_sflt_q;

  assign is_ld  = instruction_i[6:0] == OPC_LOAD;
  assign is_st  = instruction_i[6:0] == OPC_STORE;
  assign is_mem = is_ld || is_st;
  assign up_err = e_illegal_inst_i || e_inst_addr_mis_i;
  // An upstream trap takes precedence: such a bundle is never decoded further.
  assign f3_bad = is_mem && !up_err && !f3_legal(is_st, funct3_i);
  assign ok_mem = is_mem && !up_err && !f3_bad;
  assign go_bus = ok_mem && !mis;

  assign to_hit    = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST);
  assign bus_end   = dwbm_ack_i || dwbm_err_i || to_hit;
  assign bus_fault = dwbm_err_i || (to_hit && !dwbm_ack_i);

  mem_align u_align (
    .addr_lo     (alu_d_i[1:0]),
    .funct3      (funct3_i),
    .st_data     (st_d_i),
    .rsp_addr_lo (alu_q[1:0]),
    .rsp_funct3  (funct3_q),
    .rsp_data    (dwbm_dat_i),
    .sel         (al_sel),
    .lane_data   (al_dat),
    .misaligned  (mis),
    .load_data   (ld_ext)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      to_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE || state_nx == ST_IDLE) to_cnt <= '0;
      else if (to_cnt != 8'hFF)                    to_cnt <= to_cnt + 8'd1;
    end
  end

  // A flushed bus cycle cannot be aborted; DRAIN waits it out and discards it.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    deliver  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid_i && !flush_i) begin
          accept = 1'b1;
          if (go_bus) state_nx = ST_BUS;
        end
      end
      ST_BUS: begin
        if (bus_end) begin
          state_nx = ST_IDLE;
          deliver  = !flush_i;
        end else if (flush_i) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus_end) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q    <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      dat_q      <= '0;
      pc_q       <= '0;
      instr_q    <= '0;
      funct3_q   <= '0;
      rs1_q      <= '0;
      alu_q      <= '0;
      csr_addr_q <= '0;
      csr_data_q <= '0;
      mem_d_q    <= '0;
      e_ill_q    <= 1'b0;
      e_imis_q   <= 1'b0;
      e_lmis_q   <= 1'b0;
      e_smis_q   <= 1'b0;
      e_lflt_q   <= 1'b0;
      e_sflt_q   <= 1'b0;
    end else begin
      valid_q <= (accept && !go_bus) || deliver;
      if (accept) begin
        pc_q       <= pc_i;
        instr_q    <= instruction_i;
        funct3_q   <= funct3_i;
        rs1_q      <= rs1_i;
        alu_q      <= alu_d_i;
        csr_addr_q <= csr_addr_i;
        csr_data_q <= csr_data_i;
        mem_d_q    <= '0;
        e_ill_q    <= e_illegal_inst_i || f3_bad;
        e_imis_q   <= e_inst_addr_mis_i;
        e_lmis_q   <= ok_mem && is_ld && mis;
        e_smis_q   <= ok_mem && is_st && mis;
        e_lflt_q   <= 1'b0;
        e_sflt_q   <= 1'b0;
        if (go_bus) begin
          cyc_q  <= 1'b1;
          we_q   <= is_st;
          sel_q  <= al_sel;
          addr_q <= {alu_d_i[31:2], 2'b00};
          dat_q  <= al_dat;
        end
      end
      if (state != ST_IDLE && bus_end) cyc_q <= 1'b0;
      if (deliver) begin
        mem_d_q  <= (!bus_fault && !we_q) ? ld_ext : '0;
        e_lflt_q <= bus_fault && !we_q;
        e_sflt_q <= bus_fault && we_q;
      end
    end
  end

  assign stall_o           = state != ST_IDLE;
  assign state_o           = state;
  assign valid_o           = valid_q;
  assign pc_o              = pc_q;
  assign instruction_o     = instr_q;
  assign funct3_o          = funct3_q;
  assign rs1_o             = rs1_q;
  assign alu_d_o           = alu_q;
  assign csr_addr_o        = csr_addr_q;
  assign csr_data_o        = csr_data_q;
  assign mem_d_o           = mem_d_q;
  assign mem_addr_o        = alu_q;
  assign e_illegal_inst_o  = valid_q && e_ill_q;
  assign e_inst_addr_mis_o = valid_q && e_imis_q;
  assign e_ld_addr_mis_o   = valid_q && e_lmis_q;
  assign e_st_addr_mis_o   = valid_q && e_smis_q;
  assign e_ld_fault_o      = valid_q && e_lflt_q;
  assign e_st_fault_o      = valid_q && e_sflt_q;
  assign dwbm_addr_o       = addr_q;
  assign dwbm_dat_o        = dat_q;
  assign dwbm_sel_o        = sel_q;
  assign dwbm_we_o         = we_q;
  assign dwbm_cyc_o        = cyc_q;
  assign dwbm_stb_o        = cyc_q;

endmodule
